// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter: shares one single-outstanding backend memory port
// between the instruction-fetch and data ports of the pipeline. A small FSM
// remembers who owns the outstanding access so that the response is steered
// back to the right port. A streak counter limits back-to-back data grants so
// fetch cannot be starved by a long run of loads/stores.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | no request outstanding
// BUSY_I | fetch access outstanding, response goes to imem
// BUSY_D | data access outstanding, response goes to dmem
module vscale_mem_arbiter #(
    parameter int XPR_LEN        = 32,
    parameter int MEM_TYPE_WIDTH = 3,
    parameter int D_STREAK_MAX   = 4,
    parameter int CNT_W          = 3,
    // size code forwarded with fetches (full word)
    parameter logic [MEM_TYPE_WIDTH-1:0] IMEM_SIZE = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [XPR_LEN-1:0]        imem_addr_i,
    output logic                      imem_wait_o,
    output logic [XPR_LEN-1:0]        imem_rdata_o,
    output logic                      imem_badmem_e_o,
    input  logic                      dmem_en_i,
    input  logic                      dmem_wen_i,
    input  logic [MEM_TYPE_WIDTH-1:0] dmem_size_i,
    input  logic [XPR_LEN-1:0]        dmem_addr_i,
    input  logic [XPR_LEN-1:0]        dmem_wdata_delayed_i,
    output logic                      dmem_wait_o,
    output logic [XPR_LEN-1:0]        dmem_rdata_o,
    output logic                      dmem_badmem_e_o,
    output logic                      mem_req_valid_o,
    input  logic                      mem_req_ready_i,
    output logic                      mem_req_wen_o,
    output logic [MEM_TYPE_WIDTH-1:0] mem_req_size_o,
    output logic [XPR_LEN-1:0]        mem_req_addr_o,
    output logic [XPR_LEN-1:0]        mem_wdata_o,
    input  logic                      mem_resp_valid_i,
    input  logic [XPR_LEN-1:0]        mem_rdata_i,
    input  logic                      mem_badmem_e_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(D_STREAK_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             d_retry_q, d_retry_d;

    logic can_issue;
    logic grant_d;
    logic accept;
    logic resp_i;
    logic resp_d;

    // State, streak and retry registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            streak_q  <= '0;
            d_retry_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            d_retry_q <= d_retry_d;
        end
    end

    // Arbitration, next-state, streak and retry logic
    always_comb begin
        // a response frees the port in the same cycle, so a new issue can overlap it
        can_issue = !reset_i && (state_q == IDLE || mem_resp_valid_i);
        grant_d   = dmem_en_i && (streak_q < STREAK_MAX);
        accept    = can_issue && mem_req_ready_i;

        state_d   = state_q;
        streak_d  = streak_q;
        d_retry_d = 1'b0;

        if (accept) begin
            state_d = grant_d ? BUSY_D : BUSY_I;
        end else if (mem_resp_valid_i) begin
            state_d = IDLE;
        end

        if (accept) begin
            if (grant_d) begin
                if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 1'b1;
                end
            end else begin
                streak_d = '0;
            end
        end

        // data request that was not taken this cycle keeps the core stalled
        d_retry_d = dmem_en_i && !(accept && grant_d);
    end

    // Response steering and request mux
    always_comb begin
        resp_i = (state_q == BUSY_I) && mem_resp_valid_i;
        resp_d = (state_q == BUSY_D) && mem_resp_valid_i;

        mem_req_valid_o = can_issue;
        mem_req_wen_o   = grant_d ? dmem_wen_i  : 1'b0;
        mem_req_size_o  = grant_d ? dmem_size_i : IMEM_SIZE;
        mem_req_addr_o  = grant_d ? dmem_addr_i : imem_addr_i;
        mem_wdata_o     = dmem_wdata_delayed_i;

        imem_wait_o     = reset_i || !resp_i;
        dmem_wait_o     = !reset_i &&
                          (((state_q == BUSY_D) && !mem_resp_valid_i) || d_retry_q);
        imem_rdata_o    = mem_rdata_i;
        dmem_rdata_o    = mem_rdata_i;
        imem_badmem_e_o = !reset_i && resp_i && mem_badmem_e_i;
        dmem_badmem_e_o = !reset_i && resp_d && mem_badmem_e_i;
    end

endmodule
